// File: rtl/instr_fmt_pkg.sv
// Shared definitions for the instruction encoder: format codes, field
// positions of the 16-bit instruction word and the session state type.
package instr_fmt_pkg;

    localparam logic [1:0] FMT_R   = 2'd0;
    localparam logic [1:0] FMT_I5  = 2'd1;
    localparam logic [1:0] FMT_I8  = 2'd2;
    localparam logic [1:0] FMT_I11 = 2'd3;

    localparam int OP_MSB   = 15;
    localparam int W_LSB    = 8;
    localparam int A_LSB    = 5;
    localparam int B_LSB    = 2;
    localparam int IMM_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_LAST,
        ST_DONE
    } enc_state_t;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: format code plus instruction fields -> one
// instruction word in the decoder's layout.
module instr_field_packer
    import instr_fmt_pkg::*;
#(
    parameter int BITS    = 16,
    parameter int RBITS   = 3,
    parameter int OP_BITS = 5
) (
    input  logic [1:0]          fmt,
    input  logic [OP_BITS-1:0]  op,
    input  logic [RBITS-1:0]    w,
    input  logic [RBITS-1:0]    a,
    input  logic [RBITS-1:0]    b,
    input  logic [IMM_BITS-1:0] imm,
    output logic [BITS-1:0]     word
);

    // NOTE: every output of an always_comb block gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        word = '0;
        word[OP_MSB -: OP_BITS] = op;
        unique case (fmt)
            FMT_R: begin
                word[W_LSB +: RBITS] = w;
                word[A_LSB +: RBITS] = a;
                word[B_LSB +: RBITS] = b;
            end
            FMT_I5: begin
                word[W_LSB +: RBITS] = w;
                word[A_LSB +: RBITS] = a;
                word[4:0]            = imm[4:0];
            end
            FMT_I8: begin
                word[W_LSB +: RBITS] = w;
                word[7:0]            = imm[7:0];
            end
            FMT_I11: begin
                word[10:0] = imm[10:0];
            end
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Streams field-level instruction beats into sequential IMEM writes.
// Optional immediate range check: define INSTR_ENC_RANGE_CHECK_EN.
module instruction_encoder
    import instr_fmt_pkg::*;
#(
    parameter int BITS      = 16,
    parameter int RBITS     = 3,
    parameter int OP_BITS   = 5,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_fmt,
    input  logic [OP_BITS-1:0]   in_op,
    input  logic [RBITS-1:0]     in_w,
    input  logic [RBITS-1:0]     in_a,
    input  logic [RBITS-1:0]     in_b,
    input  logic [IMM_BITS-1:0]  in_imm,
    input  logic                 in_last,
    output logic                 imem_we,
    output logic [ADDR_BITS-1:0] imem_addr,
    output logic [BITS-1:0]      imem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS:0]   word_count,
    output logic                 err_wrap,
    output logic                 err_range
);

    enc_state_t           state, state_nx;
    logic [ADDR_BITS-1:0] addr;
    logic [BITS-1:0]      packed_word;
    logic                 accept;
    logic                 session_start;

    instr_field_packer #(
        .BITS    (BITS),
        .RBITS   (RBITS),
        .OP_BITS (OP_BITS)
    ) u_packer (
        .fmt  (in_fmt),
        .op   (in_op),
        .w    (in_w),
        .a    (in_a),
        .b    (in_b),
        .imm  (in_imm),
        .word (packed_word)
    );

    assign accept        = in_valid && in_ready;
    assign session_start = (state == ST_IDLE) && start;

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_RUN;
            end
            ST_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && in_last) state_nx = ST_LAST;
            end
            ST_LAST: begin
                busy     = 1'b1;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            err_wrap   <= 1'b0;
        end else begin
            state   <= state_nx;
            imem_we <= accept;
            if (session_start) begin
                addr       <= base_addr;
                word_count <= '0;
                err_wrap   <= 1'b0;
            end
            // The write is registered: the accepted beat appears on the IMEM
            // port one cycle later, at the pre-increment address.
            if (accept) begin
                imem_addr  <= addr;
                imem_wdata <= packed_word;
                addr       <= addr + ADDR_BITS'(1);
                word_count <= word_count + (ADDR_BITS+1)'(1);
                if (addr == '1) err_wrap <= 1'b1;
            end
        end
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic imm_over;

    always_comb begin
        imm_over = ((in_fmt == FMT_I5) && (|in_imm[10:5])) ||
                   ((in_fmt == FMT_I8) && (|in_imm[10:8]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_range <= 1'b0;
        end else if (session_start) begin
            err_range <= 1'b0;
        end else if (accept && imm_over) begin
            err_range <= 1'b1;
        end
    end
`else
    assign err_range = 1'b0;
`endif

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Write-side counterpart of the instruction decoder: accepts field-level instruction descriptions over a valid/ready stream and packs each into a 16-bit instruction word.
- Writes the packed words sequentially into instruction memory, starting at a programmed base address.
- Sits between the boot/program loader (or test harness) and the IMEM write port.
- Word layout matches the decoder: op[15:11], wSel[10:8], aSel[7:5], bSel[4:2], imm5[4:0], imm8[7:0], imm11[10:0].

Parameters:
- BITS, 16, instruction word width
- RBITS, 3, register-select width
- OP_BITS, 5, opcode width
- ADDR_BITS, 8, IMEM address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a load session (sampled only in IDLE)
- base_addr  in  ADDR_BITS  first IMEM address for the session
- in_valid  in  1  field beat valid
- in_ready  out  1  encoder accepts beat
- in_fmt  in  2  0=R (w,a,b), 1=I5 (w,a,imm5), 2=I8 (w,imm8), 3=I11 (imm11)
- in_op  in  OP_BITS  opcode
- in_w / in_a / in_b  in  RBITS each  register selects
- in_imm  in  11  immediate, LSB-aligned
- in_last  in  1  final beat of session
- imem_we  out  1  IMEM write strobe
- imem_addr  out  ADDR_BITS  IMEM write address
- imem_wdata  out  BITS  packed instruction
- busy  out  1  session active
- done  out  1  one-cycle pulse after the last write
- word_count  out  ADDR_BITS+1  words written this session
- err_wrap  out  1  sticky: address wrapped past max
- err_range  out  1  sticky: immediate truncated (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high): state=IDLE. in_ready, imem_we, busy, done, err_wrap and err_range are 0. imem_addr, imem_wdata and word_count are 0.
- States:
  - IDLE: on start, load addr=base_addr, clear word_count and errors, go to RUN.
  - RUN: in_ready=1 until a beat with in_last is accepted. Accept = in_valid&&in_ready.
    - On accept, the next cycle has imem_we=1, imem_wdata=packed word, imem_addr=current addr.
    - addr increments after each write; word_count increments with each write.
    - Latency is 1 cycle; throughput is 1 word/cycle.
  - LAST: entered after accepting the in_last beat. in_ready=0; the final write occurs this cycle. Go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 in RUN and LAST.
- start is ignored outside IDLE.
- in_valid is ignored outside RUN.
- Packing:
  - R: {op,w,a,b,2'b00}
  - I5: {op,w,a,imm[4:0]}
  - I8: {op,w,imm[7:0]}
  - I11: {op,imm[10:0]}
  - Unused input fields are ignored.
- Wrap-around: a write at addr=2^ADDR_BITS-1 sets addr to 0 and sets err_wrap. The session continues.
- in_last on the first beat produces a single-word session.
- Reset asserted mid-session: abandon the session immediately. No further imem_we; all outputs return to reset values.
- err flags hold until the next accepted start or reset.

Optional Feature:
- Macro: INSTR_ENC_RANGE_CHECK_EN
- Defined:
  - Any accepted beat with in_fmt=1 and in_imm[10:5]!=0, or in_fmt=2 and in_imm[10:8]!=0, sets err_range.
  - The word is still written, truncated.
- Undefined: no check logic is built; err_range is tied 0.

Decomposition:
- Package instr_fmt_pkg:
  - FMT_R/FMT_I5/FMT_I8/FMT_I11 constants
  - field bit positions (OP_MSB=15, W_LSB=8, A_LSB=5, B_LSB=2)
  - state enum
- Sub-module instr_field_packer: combinational fmt+fields -> BITS word. Reusable by assembler testbenches.

Test Plan:
- start, base_addr=0x10; one R beat op=1,w=3,a=2,b=1,last -> one write at addr 0x10, data 0x0B44; done pulse; word_count=1.
- 4 back-to-back beats, I8 op=0x18,w=7,imm=0xA5 then I5 op=6,w=1,a=4,imm=0x1F, then 2 more -> consecutive writes 0xC7A5 and 0x319F at base, base+1 onward; one write per cycle.
- base_addr=0xFF, 2 beats -> writes at 0xFF then 0x00; err_wrap=1 until next start.
- I11 op=0x1F,imm=0x7FF -> 0xFFFF. With macro: I8 imm=0x1A5 -> data 0xC7A5, err_range=1. Without macro: err_range stays 0.
- in_valid toggled with gaps; start pulsed while busy -> writes occur only on accepted beats; the session is not restarted.
- rst asserted after 2 of 5 beats -> imem_we=0 from the next cycle; IDLE; busy=0; a new start then works normally.
